// File: rtl/ssd_capture_if.sv
// ssd_capture_if -- bundle between a multiplexed 7-segment display bus and
// the capture block.
//   an           : digit anodes, active-low (an[0] = digit 0)
//   seg          : segment cathodes, active-low, bit6=a .. bit0=g
//   value        : last complete 4-digit frame
//   valid_digits : digits captured so far in the current frame
//   frame_done   : one-cycle pulse when value updates
//   err_cnt      : saturating illegal-pattern count
// master drives the display bus; slave is the capture block.
interface ssd_capture_if;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic [3:0]  valid_digits;
    logic        frame_done;
    logic [7:0]  err_cnt;

    modport master (output an, seg, input value, valid_digits, frame_done, err_cnt);
    modport slave  (input an, seg, output value, valid_digits, frame_done, err_cnt);
endinterface

// File: rtl/ssd_capture.sv
// ssd_capture -- watches a multiplexed 7-segment display bus and rebuilds the
// 16-bit hex value being shown.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ssd_capture_if.slave (an/seg in; value/valid_digits/frame_done/err_cnt out)
// Parameter STABLE_CYCLES (2..15): edges an anode/segment pair must hold
// before its digit is evaluated.
// Optional feature: define SSD_CAPTURE_ERR_EN to build the saturating
// illegal-pattern counter; otherwise err_cnt is tied to zero.
module ssd_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ssd_capture_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HELD   = 2'd2;

    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] value_q, value_d;
    logic        frame_done_q, frame_done_d;
    logic        err_evt;

    logic        pair_chg;
    logic [1:0]  idx;
    logic        legal;
    logic [3:0]  nib;
    logic [3:0]  seen_new;

    // Inverse of the hex-to-segment table; anything not listed is illegal.
    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        unique case (seg_q)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
            default:    legal = 1'b0;
        endcase
    end

    // Only consulted in SETTLE, where an_q is known to be one-hot-low.
    always_comb begin
        case (an_q)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        an_d         = bus.an;
        seg_d        = bus.seg;
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        seen_d       = seen_q;
        value_d      = value_q;
        frame_done_d = 1'b0;
        err_evt      = 1'b0;
        seen_new     = seen_q | (4'b0001 << idx);
        pair_chg     = (bus.an != an_q) || (bus.seg != seg_q);

        if (pair_chg) begin
            // New pair: restart the stability count on the loading edge.
            cnt_d   = 4'd1;
            state_d = $onehot(~bus.an) ? S_SETTLE : S_IDLE;
        end else if (state_q == S_SETTLE) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == 4'(STABLE_CYCLES)) begin
                state_d = S_HELD;
                if (legal) begin
                    shadow_d[{idx, 2'b00} +: 4] = nib;
                    if (seen_new == 4'b1111) begin
                        value_d      = shadow_d;
                        frame_done_d = 1'b1;
                        seen_d       = 4'b0000;
                    end else begin
                        seen_d = seen_new;
                    end
                end else if (seg_q != 7'b1111111) begin
                    // Blank digit is a legitimate display state, not an error.
                    err_evt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            shadow_q     <= 16'h0000;
            seen_q       <= 4'b0000;
            value_q      <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            seen_q       <= seen_d;
            value_q      <= value_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef SSD_CAPTURE_ERR_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 8'h00;
        else        err_cnt_q <= err_cnt_d;
    end

    assign bus.err_cnt = err_cnt_q;
`else
    // Error events are still detected but nothing consumes them.
    logic unused_err;
    assign unused_err  = err_evt;
    assign bus.err_cnt = 8'h00;
`endif

    assign bus.value        = value_q;
    assign bus.valid_digits = seen_q;
    assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture (STABLE_CYCLES = 4). Expectations follow
// the build: SSD_CAPTURE_ERR_EN selects counting vs. tied-zero err_cnt.
module tb_ssd_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fd_cnt = 0;
    int   fd_base;

    ssd_capture_if bus ();

    ssd_capture #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // frame_done pulses counted on the falling edge, away from updates.
    always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

`ifdef SSD_CAPTURE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a pair right after a rising edge and hold it for n edges.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an  = an;
        bus.seg = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        #2;
        check("rst_value", bus.value, 16'h0000);
        check("rst_valid", 16'(bus.valid_digits), 16'h0);
        check("rst_fd", 16'(bus.frame_done), 16'h0);
        check("rst_err", 16'(bus.err_cnt), 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame D A 4 3.
        fd_base = fd_cnt;
        drive(4'b1110, 7'b0000110, 6);
        check("s1_valid_d0", 16'(bus.valid_digits), 16'h1);
        drive(4'b1101, 7'b1001100, 6);
        drive(4'b1011, 7'b0001000, 6);
        check("s1_valid_d2", 16'(bus.valid_digits), 16'h7);
        check("s1_value_partial", bus.value, 16'h0000);
        drive(4'b0111, 7'b1000010, 6);
        check("s1_value", bus.value, 16'hDA43);
        check("s1_valid", 16'(bus.valid_digits), 16'h0);
        check("s1_fd_pulses", 16'(fd_cnt - fd_base), 16'd1);
        check("s1_fd_low", 16'(bus.frame_done), 16'h0);

        // Segment toggling every 2 cycles never settles.
        for (int i = 0; i < 10; i++)
            drive(4'b1110, (i % 2 == 0) ? 7'b0000001 : 7'b1001111, 2);
        check("s2_valid", 16'(bus.valid_digits), 16'h0);

        // Illegal pattern held 8 cycles: exactly one error event.
        drive(4'b1101, 7'b1111110, 8);
        check("s3_err", 16'(bus.err_cnt), ERR_EN ? 16'd1 : 16'd0);
        check("s3_valid", 16'(bus.valid_digits), 16'h0);
        // Long hold of another illegal pattern still counts once.
        drive(4'b1101, 7'b1111100, 30);
        check("s3_err_long", 16'(bus.err_cnt), ERR_EN ? 16'd2 : 16'd0);

        // Two anodes low, then none low: ignored.
        drive(4'b1100, 7'b0000000, 10);
        drive(4'b1111, 7'b0000000, 10);
        check("s4_valid", 16'(bus.valid_digits), 16'h0);
        check("s4_err", 16'(bus.err_cnt), ERR_EN ? 16'd2 : 16'd0);

        // Blank digit: no capture, no error.
        drive(4'b1110, 7'b1111111, 8);
        check("blank_valid", 16'(bus.valid_digits), 16'h0);
        check("blank_err", 16'(bus.err_cnt), ERR_EN ? 16'd2 : 16'd0);

        // Overwrite digit 0 (1 then 5) before frame completes -> F725.
        fd_base = fd_cnt;
        drive(4'b1110, 7'b1001111, 6);
        drive(4'b1110, 7'b0100100, 6);
        check("ow_valid", 16'(bus.valid_digits), 16'h1);
        drive(4'b1101, 7'b0010010, 6);
        drive(4'b1011, 7'b0001111, 6);
        drive(4'b0111, 7'b0111000, 6);
        check("ow_value", bus.value, 16'hF725);
        check("ow_fd_pulses", 16'(fd_cnt - fd_base), 16'd1);

        // Reset mid-frame discards digits 0..2.
        drive(4'b1110, 7'b0000001, 6);
        drive(4'b1101, 7'b1001111, 6);
        drive(4'b1011, 7'b0010010, 6);
        check("s5_valid_pre", 16'(bus.valid_digits), 16'h7);
        bus.an  = 4'b0111;
        bus.seg = 7'b0000110;
        rst_n   = 1'b0;
        #1;
        check("s5_rst_value", bus.value, 16'h0000);
        check("s5_rst_valid", 16'(bus.valid_digits), 16'h0);
        check("s5_rst_err", 16'(bus.err_cnt), 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fd_base = fd_cnt;
        drive(4'b0111, 7'b0000110, 6);
        check("s5_valid", 16'(bus.valid_digits), 16'h8);
        check("s5_value", bus.value, 16'h0000);
        check("s5_fd_pulses", 16'(fd_cnt - fd_base), 16'd0);

        // 300 illegal stable periods: saturation.
        for (int i = 0; i < 300; i++)
            drive(4'b1110, (i % 2 == 0) ? 7'b1111110 : 7'b1111100, 5);
        check("s6_err_sat", 16'(bus.err_cnt), ERR_EN ? 16'h00FF : 16'h0000);
        check("s6_valid", 16'(bus.valid_digits), 16'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ssd_capture.md
SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, range 2..15; consecutive clock edges an anode/segment pair must hold before its digit is captured.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 an  input  4  digit anodes, active-low; an[0] selects digit 0 (value[3:0]), an[3] selects digit 3 (value[15:12]).
REQ-005 seg  input  7  segment cathodes, active-low, bit6=a ... bit0=g.
REQ-006 value  output  16  last complete decoded 4-digit frame.
REQ-007 valid_digits  output  4  digits captured in the current, not yet complete, frame.
REQ-008 frame_done  output  1  one-cycle pulse when value is updated.
REQ-009 err_cnt  output  8  illegal-pattern count, saturating.

Function
REQ-010 The block shall reverse the team's hex-to-segment display encoding: watch a multiplexed display bus and reconstruct the shown hex value.
REQ-011 Decode table (seg -> nibble) shall be exactly: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-012 an and seg shall be registered once (pair register) before any comparison; no other synchronizer.
REQ-013 FSM states: IDLE (anode not one-hot), SETTLE (counting stability), HELD (pair captured or rejected, waiting for change).
REQ-014 When the pair register loads a value that differs from its previous contents: cnt<=1; state <= SETTLE if an is one-hot-low, else IDLE.
REQ-015 In SETTLE, each edge with an unchanged pair shall increment cnt; the edge on which cnt reaches STABLE_CYCLES shall evaluate the pair and move to HELD.
REQ-016 Evaluation, legal pattern: shadow[digit] <= nibble, seen[digit] <= 1.
REQ-017 Evaluation, seg = 1111111 (blank): no capture, no error, seen unchanged.
REQ-018 Evaluation, any other pattern: no capture, seen unchanged, error event (REQ-027).
REQ-019 HELD shall not re-evaluate; exactly one evaluation per stable period, however long the pair holds.
REQ-020 On an evaluation edge making seen|newbit == 4'b1111: value <= shadow merged with the new nibble, frame_done <= 1, seen <= 0, all on that same edge.
REQ-021 frame_done shall be high for exactly one cycle per completed frame.
REQ-022 Re-capturing an already-seen digit before frame completion shall overwrite its shadow nibble without changing seen.
REQ-023 No anode low, or more than one anode low: state IDLE, no evaluation, seen and shadow retained.
REQ-024 valid_digits shall equal seen; value shall change only on frame completion.

Reset
REQ-025 rst_n low shall immediately set: value=0, valid_digits=0, frame_done=0, err_cnt=0, shadow=0, cnt=0, state=IDLE, pair register an=4'b1111, seg=7'b1111111.
REQ-026 Reset mid-frame shall discard partial captures; after release the first frame_done requires all four digits captured anew.

Configuration
REQ-027 Macro SSD_CAPTURE_ERR_EN defined: each error event shall increment err_cnt by 1, saturating at 255.
REQ-028 Macro SSD_CAPTURE_ERR_EN undefined: err_cnt shall be held at 0, the error counter shall not be built, and illegal patterns shall otherwise be handled exactly as in REQ-018.

Verification
REQ-029 Scenario: reset, then drive an=1110/seg=0000110, an=1101/seg=1001100, an=1011/seg=0001000, an=0111/seg=1000010, 6 cycles each -> a single frame_done pulse, value=16'hDA43, valid_digits=0.
REQ-030 Scenario: an=1110 with seg toggling every 2 cycles for 20 cycles (STABLE_CYCLES=4) -> no capture, valid_digits=0.
REQ-031 Scenario: an=1101, seg=1111110 held 8 cycles -> ERR_EN defined: err_cnt=1, valid_digits unchanged; ERR_EN undefined: err_cnt=0.
REQ-032 Scenario: an=1100 with seg=0000000 held 10 cycles, then an=1111 held 10 cycles -> no capture, no error.
REQ-033 Scenario: capture digits 0,1,2, assert rst_n low for 1 cycle, then capture digit 3 only -> no frame_done, valid_digits=4'b1000, value=0.
REQ-034 Scenario: 300 illegal stable periods with SSD_CAPTURE_ERR_EN defined -> err_cnt saturates at 8'hFF.
